sync_fifo_param: RTL

Single-clock, parametrised first-in-first-out buffer with configurable data width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the general-purpose buffering block for same-clock producer/consumer pairs. Data is stored in a register array indexed by wrap-around pointers that are one bit wider than the address, so full and empty are never ambiguous.

---
 rtl/sync_fifo_param_if.sv | 40 ++++
 rtl/sync_fifo_param.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Bundle of the FIFO's control, data and status signals.
//   master : producer/consumer side (drives clr, wr, rd, data_in; observes
//            data_out, rd_valid, the occupancy flags, count and error flags)
//   slave  : the FIFO itself
// Parameters must match the connected sync_fifo_param instance.
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr, rd, data_in,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr, rd, data_in,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with register-array storage, wrap-bit pointers, an
// occupancy counter, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset (memory contents not reset)
//   fifo    : sync_fifo_param_if.slave
//     clr          in  synchronous flush, wins over wr/rd
//     wr / rd      in  write / read requests
//     data_in      in  write data
//     data_out     out registered read data
//     rd_valid     out data_out was loaded by a read on the previous edge
//     empty/full   out count == 0 / count == DEPTH
//     almost_empty out count <= AEMPTY_TH
//     almost_full  out count >= AFULL_TH
//     count        out occupancy 0..DEPTH
//     overflow     out sticky: write requested while full
//     underflow    out sticky: read requested while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  sync_fifo_param_if.slave  fifo
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]    PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0]    CNT_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0]    CNT_AFULL = PW'(AFULL_TH);
  localparam logic [PW-1:0]    CNT_AEMP  = PW'(AEMPTY_TH);
  localparam logic [WIDTH-1:0] DATA_ZERO = WIDTH'(0);

  // Storage; intentionally has no reset so it maps onto plain flops/RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [PW-1:0]    count_q,     count_d;
  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic             rd_valid_q,  rd_valid_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty_s;
  logic             full_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             mem_we_s;

  // Status flags come from the registered count only, so nothing on the
  // request side can reach an output combinationally.
  assign empty_s  = (count_q == PTR_ZERO);
  assign full_s   = (count_q == CNT_FULL);

  // Acceptance is judged on the flags as they stand at this edge; a read
  // on full does not make room for a write in the same cycle.
  assign wr_acc_s = fifo.wr & ~full_s;
  assign rd_acc_s = fifo.rd & ~empty_s;
  assign mem_we_s = wr_acc_s & ~fifo.clr;

  // Next-state for pointers, count, read data and the sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo.clr) begin
      // Flush discards concurrent requests and raises no error flags.
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      count_d     = PTR_ZERO;
      data_out_d  = DATA_ZERO;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
      end

      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase

      overflow_d  = overflow_q  | (fifo.wr & full_s);
      underflow_d = underflow_q | (fifo.rd & empty_s);
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= PTR_ZERO;
      data_out_q  <= DATA_ZERO;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fifo.data_in;
    end
  end

  assign fifo.data_out     = data_out_q;
  assign fifo.rd_valid     = rd_valid_q;
  assign fifo.count        = count_q;
  assign fifo.empty        = empty_s;
  assign fifo.full         = full_s;
  assign fifo.almost_empty = (count_q <= CNT_AEMP);
  assign fifo.almost_full  = (count_q >= CNT_AFULL);
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule
